// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Brief    : Sequential integer ALU. Logic, shift, compare and branch ops
//             finish in one cycle; multiply/divide iterate one bit per cycle
//             (radix-2 shift-add, restoring division) with sign fix-up at
//             the end. Valid/ready request and result channels.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] resC,
    output logic            branch
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [4:0] c_OP_ADD  = 5'h00;
    localparam logic [4:0] c_OP_SUB  = 5'h01;
    localparam logic [4:0] c_OP_AND  = 5'h02;
    localparam logic [4:0] c_OP_OR   = 5'h03;
    localparam logic [4:0] c_OP_XOR  = 5'h04;
    localparam logic [4:0] c_OP_SLL  = 5'h05;
    localparam logic [4:0] c_OP_SRL  = 5'h06;
    localparam logic [4:0] c_OP_SRA  = 5'h07;
    localparam logic [4:0] c_OP_BEQ  = 5'h08;
    localparam logic [4:0] c_OP_BNE  = 5'h09;
    localparam logic [4:0] c_OP_BLT  = 5'h0A;
    localparam logic [4:0] c_OP_BGE  = 5'h0B;
    localparam logic [4:0] c_OP_BLTU = 5'h0C;
    localparam logic [4:0] c_OP_BGEU = 5'h0D;
    localparam logic [4:0] c_OP_SLT  = 5'h0E;
    localparam logic [4:0] c_OP_SLTU = 5'h0F;

    localparam logic [SHW-1:0] c_CNT_INIT = SHW'(XLEN - 1);
    localparam logic [SHW-1:0] c_CNT_ONE  = SHW'(1);

    // FSM and datapath state
    logic [1:0]      r_state;
    logic [SHW-1:0]  r_cnt;
    logic [2:0]      r_op;      // low bits of an iterative op code (0x10-0x17)
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // product low half + multiplier / quotient + dividend
    logic [XLEN-1:0] r_opnd;    // multiplicand magnitude / divisor magnitude
    logic [XLEN-1:0] r_a;       // original opA, returned by remainder-by-zero
    logic            r_neg;     // negate the final magnitude result
    logic            r_bz;      // divisor was zero
    logic [XLEN-1:0] r_res;
    logic            r_branch;

    // single-cycle results and iterative set-up values
    logic [XLEN-1:0] w_alu_res;
    logic            w_alu_br;
    logic [SHW-1:0]  w_shamt;
    logic            w_iter;
    logic            w_sa;
    logic            w_sb;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_neg;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;

    // per-iteration step and final fix-up
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_hi_n;
    logic [XLEN-1:0]   w_lo_n;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fin;

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign resC      = r_res;
    assign branch    = r_branch;
    assign w_shamt   = opB[SHW-1:0];

    // single-cycle ops evaluated straight from the request operands
    always_comb begin
        w_alu_res = '0;
        w_alu_br  = 1'b0;
        case (op)
            c_OP_ADD:  w_alu_res = opA + opB;
            c_OP_SUB:  w_alu_res = opA - opB;
            c_OP_AND:  w_alu_res = opA & opB;
            c_OP_OR:   w_alu_res = opA | opB;
            c_OP_XOR:  w_alu_res = opA ^ opB;
            c_OP_SLL:  w_alu_res = opA << w_shamt;
            c_OP_SRL:  w_alu_res = opA >> w_shamt;
            c_OP_SRA:  w_alu_res = $unsigned($signed(opA) >>> w_shamt);
            c_OP_BEQ:  w_alu_br  = (opA == opB);
            c_OP_BNE:  w_alu_br  = (opA != opB);
            c_OP_BLT:  w_alu_br  = ($signed(opA) <  $signed(opB));
            c_OP_BGE:  w_alu_br  = ($signed(opA) >= $signed(opB));
            c_OP_BLTU: w_alu_br  = (opA <  opB);
            c_OP_BGEU: w_alu_br  = (opA >= opB);
            c_OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
            c_OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (opA < opB)};
            default: begin
                w_alu_res = '0;
                w_alu_br  = 1'b0;
            end
        endcase
    end

    // operand magnitudes and result sign for multiply/divide
    // op[2]=divide, op[1]=remainder (divide) ; op[1:0]=01 MULH, 10 MULHSU
    always_comb begin
        w_iter  = (op[4:3] == 2'b10);
        w_sa    = op[2] ? ~op[0] : (op[1] ^ op[0]);
        w_sb    = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        w_a_neg = w_sa & opA[XLEN-1];
        w_b_neg = w_sb & opB[XLEN-1];
        w_neg   = (op[2] & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_mag_a = w_a_neg ? -opA : opA;
        w_mag_b = w_b_neg ? -opB : opB;
    end

    // one shift-add or restoring-divide step, plus the completion fix-up
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        w_diff  = w_shift[XLEN-1:0] - r_opnd;
        if (r_op[2]) begin
            w_hi_n = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_n = w_sum[XLEN:1];
            w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod_fix = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
        w_quot_fix = r_neg ? -w_lo_n : w_lo_n;
        w_rem_fix  = r_neg ? -w_hi_n : w_hi_n;
        // Overflow (most-negative / -1) needs no special case: the magnitude
        // quotient 2^(XLEN-1) with positive sign already equals opA, rem 0.
        if (!r_op[2]) begin
            w_fin = (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        end else if (r_op[1]) begin
            w_fin = r_bz ? r_a : w_rem_fix;
        end else begin
            w_fin = r_bz ? {XLEN{1'b1}} : w_quot_fix;
        end
    end

    // control FSM with registered result; flush beats acceptance and out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_a      <= '0;
            r_neg    <= 1'b0;
            r_bz     <= 1'b0;
            r_res    <= '0;
            r_branch <= 1'b0;
        end else if (flush) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        if (w_iter) begin
                            r_state <= c_ST_BUSY;
                            r_cnt   <= c_CNT_INIT;
                            r_op    <= op[2:0];
                            r_a     <= opA;
                            r_bz    <= (opB == '0);
                            r_neg   <= w_neg;
                            r_hi    <= '0;
                            if (op[2]) begin
                                r_lo   <= w_mag_a;
                                r_opnd <= w_mag_b;
                            end else begin
                                r_lo   <= w_mag_b;
                                r_opnd <= w_mag_a;
                            end
                        end else begin
                            r_state  <= c_ST_DONE;
                            r_res    <= w_alu_res;
                            r_branch <= w_alu_br;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_hi <= w_hi_n;
                    r_lo <= w_lo_n;
                    if (r_cnt == '0) begin
                        r_state  <= c_ST_DONE;
                        r_res    <= w_fin;
                        r_branch <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; legal values 8..64, power of two.
REQ-002 SHALL derive localparam SHW = $clog2(XLEN): number of shift-amount bits taken from opB.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1: synchronous abort of any in-flight operation.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: block accepts a request this cycle.
REQ-008 SHALL have port op, input, 5: operation code (REQ-012).
REQ-009 SHALL have ports opA and opB, input, XLEN each: operands.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), resC (output, XLEN), branch (output, 1): result channel.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-012 Op codes SHALL be: 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 SLL, 06 SRL, 07 SRA, 08 BEQ, 09 BNE, 0A BLT, 0B BGE, 0C BLTU, 0D BGEU, 0E SLT, 0F SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
REQ-013 Request SHALL be accepted when in_valid && in_ready && !flush; op and operands captured at that edge.
REQ-014 Ops 00-0F and undefined codes SHALL be single-cycle: IDLE -> DONE; out_valid asserted the cycle after acceptance.
REQ-015 Ops 10-17 SHALL be iterative: IDLE -> BUSY, exactly XLEN BUSY cycles (counter XLEN-1 down to 0), then DONE; out_valid asserted XLEN+1 cycles after acceptance.
REQ-016 Multiply SHALL be radix-2 shift-add on 2*XLEN-bit product; MUL returns low half, MULH/MULHSU/MULHU high half with signed*signed, signed*unsigned, unsigned*unsigned semantics.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, on operand magnitudes with sign fix-up at completion (quotient sign = sign(A) xor sign(B); remainder sign = sign(A)).
REQ-018 Divide by zero SHALL return quotient all-ones (DIV, DIVU) and remainder = opA (REM, REMU).
REQ-019 Signed overflow (opA = most-negative, opB = -1) SHALL return quotient = opA and remainder = 0.
REQ-020 Shifts SHALL use opB[SHW-1:0] only; SRA sign-extends.
REQ-021 ADD/SUB SHALL wrap modulo 2^XLEN; no carry/overflow output.
REQ-022 Branch ops (08-0D) SHALL set branch to the compare result and resC = 0; all other ops SHALL drive branch = 0.
REQ-023 SLT/SLTU SHALL return resC = 1 or 0 (zero-extended), branch = 0.
REQ-024 Undefined codes (18-1F) SHALL complete single-cycle with resC = 0, branch = 0.
REQ-025 In DONE, resC/branch SHALL hold stable until out_ready is sampled high; then -> IDLE next cycle.
REQ-026 in_valid SHALL be ignored outside IDLE; at most one operation in flight; no back-to-back acceptance (minimum 2 cycles per op).
REQ-027 flush SHALL force state to IDLE at the next edge from any state, discard the result, and take priority over acceptance and out_ready.
REQ-028 resC and branch SHALL be registered outputs; no combinational path from inputs to resC/branch.

Reset
REQ-029 On rst_n low, state = IDLE, counter = 0, resC = 0, branch = 0, out_valid = 0 immediately, without waiting for clk.
REQ-030 in_ready SHALL be 1 from the first edge after rst_n deasserts; reset mid-BUSY discards the operation.

Verification
REQ-031 XLEN=32, op=00, A=0xFFFFFFFF, B=1, out_ready=1 -> out_valid next cycle, resC=0x00000000, branch=0.
REQ-032 op=13 (MULHU), A=B=0xFFFFFFFF -> out_valid after 33 cycles, resC=0xFFFFFFFE; op=11 (MULH), A=0xFFFFFFFF (-1), B=2 -> resC=0xFFFFFFFF.
REQ-033 op=14 (DIV), A=0x80000000, B=0xFFFFFFFF -> resC=0x80000000; op=16 (REM) same operands -> resC=0; op=15 (DIVU), B=0 -> resC=0xFFFFFFFF.
REQ-034 op=0A (BLT), A=0xFFFFFFFE, B=1 -> branch=1, resC=0; op=0C (BLTU), same operands -> branch=0.
REQ-035 Backpressure: DIV completes with out_ready=0 for 5 cycles -> resC/out_valid stable, in_ready=0; in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 flush asserted at BUSY cycle 10 of MUL -> IDLE next cycle, no out_valid; rst_n pulsed low mid-BUSY -> outputs 0 asynchronously; XLEN=8 regression: op=05, A=0x01, B=0x09 -> resC=0x02.
